// File: rtl/apb_master.sv
// APB requester: turns a one-cycle CPU transfer strobe into an APB SETUP/ACCESS
// sequence toward up to four slaves, with address decode, PREADY timeout and error reporting.
module apb_master #(
   parameter int         TIMEOUT = 16,
   parameter logic [3:0] BASE_HI = 4'h1
) (
   input  logic        PCLK,
   input  logic        PRESET,
   input  logic        transfer,
   input  logic        write,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        ready,
   output logic        err,
   output logic        busy,
   output logic [31:0] PADDR,
   output logic [31:0] PWDATA,
   output logic        PWRITE,
   output logic [3:0]  PSEL,
   output logic        PENABLE,
   input  logic [31:0] PRDATA0,
   input  logic [31:0] PRDATA1,
   input  logic [31:0] PRDATA2,
   input  logic [31:0] PRDATA3,
   input  logic        PREADY0,
   input  logic        PREADY1,
   input  logic        PREADY2,
   input  logic        PREADY3,
   output logic [1:0]  state_dbg
);

   // Request side handshake: transfer is accepted on any edge where the block is
   // idle or completing; ready is a one-cycle pulse, with rdata/err valid only while it is high.

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } state_t;

   localparam logic [4:0] WAIT_LAST = 5'(TIMEOUT - 1);

   state_t      state_q, state_d;
   logic [31:0] paddr_q, paddr_d;
   logic [31:0] pwdata_q, pwdata_d;
   logic        pwrite_q, pwrite_d;
   logic [3:0]  psel_q, psel_d;
   logic        penable_q, penable_d;
   logic        mapped_q, mapped_d;
   logic [1:0]  sel_q, sel_d;
   logic [4:0]  wait_q, wait_d;
   logic [31:0] rdata_q, rdata_d;
   logic        ready_q, ready_d;
   logic        err_q, err_d;
   logic        busy_q, busy_d;

   logic        completing;
   logic        req_mapped;
   logic        sel_ready;
   logic [31:0] sel_rdata;

   assign req_mapped = (addr[31:28] == BASE_HI) && (addr[27:14] == 14'd0);

   // Only the latched slave's response is ever looked at.
   always_comb begin
      sel_ready = 1'b0;
      sel_rdata = 32'd0;
      case (sel_q)
         2'd0: begin sel_ready = PREADY0; sel_rdata = PRDATA0; end
         2'd1: begin sel_ready = PREADY1; sel_rdata = PRDATA1; end
         2'd2: begin sel_ready = PREADY2; sel_rdata = PRDATA2; end
         default: begin sel_ready = PREADY3; sel_rdata = PRDATA3; end
      endcase
   end

   always_comb begin
      state_d    = state_q;
      paddr_d    = paddr_q;
      pwdata_d   = pwdata_q;
      pwrite_d   = pwrite_q;
      psel_d     = psel_q;
      penable_d  = penable_q;
      mapped_d   = mapped_q;
      sel_d      = sel_q;
      wait_d     = wait_q;
      rdata_d    = rdata_q;
      ready_d    = 1'b0;
      err_d      = 1'b0;
      busy_d     = busy_q;
      completing = 1'b0;

      case (state_q)
         IDLE: begin
         end
         SETUP: begin
            state_d   = ACCESS;
            penable_d = 1'b1;
            wait_d    = 5'd0;
         end
         ACCESS: begin
            if (!mapped_q) begin
               completing = 1'b1;
               err_d      = 1'b1;
               rdata_d    = 32'd0;
            end else if (sel_ready) begin
               completing = 1'b1;
               if (!pwrite_q) rdata_d = sel_rdata;
            end else if (wait_q == WAIT_LAST) begin
               completing = 1'b1;
               err_d      = 1'b1;
               rdata_d    = 32'd0;
            end else begin
               wait_d = wait_q + 5'd1;
            end
         end
         default: state_d = IDLE;
      endcase

      if (completing) begin
         ready_d   = 1'b1;
         state_d   = IDLE;
         psel_d    = 4'b0000;
         penable_d = 1'b0;
         busy_d    = 1'b0;
      end

      // A request on the completing edge chains straight into SETUP.
      if (transfer && ((state_q == IDLE) || completing)) begin
         state_d   = SETUP;
         paddr_d   = addr;
         pwdata_d  = wdata;
         pwrite_d  = write;
         mapped_d  = req_mapped;
         sel_d     = addr[13:12];
         psel_d    = req_mapped ? (4'b0001 << addr[13:12]) : 4'b0000;
         penable_d = 1'b0;
         busy_d    = 1'b1;
      end
   end

   always_ff @(posedge PCLK or negedge PRESET) begin
      if (!PRESET) begin
         state_q   <= IDLE;
         paddr_q   <= 32'd0;
         pwdata_q  <= 32'd0;
         pwrite_q  <= 1'b0;
         psel_q    <= 4'b0000;
         penable_q <= 1'b0;
         mapped_q  <= 1'b0;
         sel_q     <= 2'd0;
         wait_q    <= 5'd0;
         rdata_q   <= 32'd0;
         ready_q   <= 1'b0;
         err_q     <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         paddr_q   <= paddr_d;
         pwdata_q  <= pwdata_d;
         pwrite_q  <= pwrite_d;
         psel_q    <= psel_d;
         penable_q <= penable_d;
         mapped_q  <= mapped_d;
         sel_q     <= sel_d;
         wait_q    <= wait_d;
         rdata_q   <= rdata_d;
         ready_q   <= ready_d;
         err_q     <= err_d;
         busy_q    <= busy_d;
      end
   end

   assign rdata     = rdata_q;
   assign ready     = ready_q;
   assign err       = err_q;
   assign busy      = busy_q;
   assign PADDR     = paddr_q;
   assign PWDATA    = pwdata_q;
   assign PWRITE    = pwrite_q;
   assign PSEL      = psel_q;
   assign PENABLE   = penable_q;
   assign state_dbg = state_q;

endmodule

// File: tb/tb_apb_master.sv
// Bench for apb_master: slave 0 answers with zero wait states, slaves 1-3 with a
// registered PREADY; a monitor scores every ready pulse against the expected queue.
module tb_apb_master;

   localparam int W = 41;  // {latency[7:0], err, rdata[31:0]}

   logic        PCLK = 1'b0;
   logic        PRESET = 1'b0;
   logic        transfer = 1'b0;
   logic        write = 1'b0;
   logic [31:0] addr = 32'd0;
   logic [31:0] wdata = 32'd0;
   logic [31:0] rdata;
   logic        ready, err, busy;
   logic [31:0] PADDR, PWDATA;
   logic        PWRITE, PENABLE;
   logic [3:0]  PSEL;
   logic [31:0] PRDATA0, PRDATA1, PRDATA2, PRDATA3;
   logic        PREADY0, PREADY1, PREADY2, PREADY3;
   logic [1:0]  state_dbg;

   apb_master #(.TIMEOUT(16), .BASE_HI(4'h1)) dut (
      .PCLK(PCLK), .PRESET(PRESET), .transfer(transfer), .write(write),
      .addr(addr), .wdata(wdata), .rdata(rdata), .ready(ready), .err(err),
      .busy(busy), .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE),
      .PSEL(PSEL), .PENABLE(PENABLE),
      .PRDATA0(PRDATA0), .PRDATA1(PRDATA1), .PRDATA2(PRDATA2), .PRDATA3(PRDATA3),
      .PREADY0(PREADY0), .PREADY1(PREADY1), .PREADY2(PREADY2), .PREADY3(PREADY3),
      .state_dbg(state_dbg)
   );

   // clock / cycle counter
   always #5 PCLK = ~PCLK;
   int cyc = 0;
   always @(posedge PCLK) cyc <= cyc + 1;

   // slave models
   logic [31:0] mem [4][4];
   logic [3:1]  pready_r;
   logic        hang2 = 1'b0;
   logic [3:0]  pready_v;

   always @(posedge PCLK or negedge PRESET) begin
      if (!PRESET) pready_r <= 3'b000;
      else for (int i = 1; i < 4; i++) pready_r[i] <= PSEL[i] && PENABLE && !pready_r[i];
   end
   assign PREADY0 = 1'b1;
   assign PREADY1 = pready_r[1];
   assign PREADY2 = pready_r[2] & ~hang2;
   assign PREADY3 = pready_r[3];
   assign pready_v = {PREADY3, PREADY2, PREADY1, PREADY0};
   always @(posedge PCLK) begin
      for (int i = 0; i < 4; i++)
         if (PSEL[i] && PENABLE && PWRITE && pready_v[i]) mem[i][PADDR[3:2]] <= PWDATA;
   end
   assign PRDATA0 = mem[0][PADDR[3:2]];
   assign PRDATA1 = mem[1][PADDR[3:2]];
   assign PRDATA2 = mem[2][PADDR[3:2]];
   assign PRDATA3 = mem[3][PADDR[3:2]];

   // scoreboard
   int n_checks = 0;
   int n_fail = 0;
   int n_issued = 0;
   int n_done = 0;
   logic [W-1:0] exp_q[$];
   int issue_q[$];
   logic [W-1:0] e_cur;
   int t_cur;
   logic ready_prev = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(negedge PCLK) begin
      if (PRESET && ready) begin
         check("ready_one_cycle", {63'd0, ready_prev}, 64'd0);
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_ready: got ready=1 expected no completion (cycle %0d)", cyc);
         end else begin
            e_cur = exp_q.pop_front();
            t_cur = issue_q.pop_front();
            check("rdata", rdata, e_cur[31:0]);
            check("err", err, e_cur[32]);
            check("latency", cyc - t_cur, e_cur[40:33]);
            n_done++;
         end
      end
      ready_prev = ready;
   end

   // driver tasks
   task automatic push_exp(input logic [31:0] r, input logic e, input int lat);
      issue_q.push_back(cyc);
      exp_q.push_back({8'(lat), e, r});
      n_issued++;
   endtask

   task automatic wait_idle(input int budget);
      int k = 0;
      while ((n_done != n_issued || busy) && k < budget) begin
         @(negedge PCLK);
         k++;
      end
      if (n_done != n_issued || busy) begin
         n_checks++;
         n_fail++;
         $display("FAIL wait_idle: got done=%0d busy=%0b expected done=%0d busy=0", n_done, busy, n_issued);
      end
   endtask

   task automatic wait_ready(input int budget);
      int k = 0;
      do begin
         @(negedge PCLK);
         k++;
      end while (!ready && k < budget);
      if (!ready) begin
         n_checks++;
         n_fail++;
         $display("FAIL wait_ready: got ready=0 expected ready=1 within %0d cycles", budget);
      end
   endtask

   task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] r, input logic e, input int lat,
                       input logic [3:0] exp_psel, input string tag);
      @(negedge PCLK);
      transfer = 1'b1; write = w; addr = a; wdata = d;
      @(posedge PCLK); #1;
      push_exp(r, e, lat);
      transfer = 1'b0;
      @(negedge PCLK);
      check({tag, "_psel"}, PSEL, exp_psel);
      check({tag, "_paddr"}, PADDR, a);
      check({tag, "_pwrite"}, PWRITE, w);
      check({tag, "_penable_setup"}, PENABLE, 1'b0);
      wait_idle(40);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got no end of test expected finish before 100us");
      $fatal(1);
   end

   initial begin
      repeat (3) @(negedge PCLK);
      check("rst_psel", PSEL, 4'b0000);
      check("rst_penable", PENABLE, 1'b0);
      check("rst_pwrite", PWRITE, 1'b0);
      check("rst_paddr", PADDR, 32'd0);
      check("rst_pwdata", PWDATA, 32'd0);
      check("rst_rdata", rdata, 32'd0);
      check("rst_ready_err", {ready, err}, 2'b00);
      check("rst_busy", busy, 1'b0);
      check("rst_state", state_dbg, 2'd0);
      PRESET = 1'b1;
      repeat (2) @(negedge PCLK);

      // write then read through registered-PREADY slave 1
      xfer(1'b1, 32'h1000_1004, 32'hDEAD_BEEF, 32'h0, 1'b0, 3, 4'b0010, "wr_s1");
      check("wr_s1_pwdata", PWDATA, 32'hDEAD_BEEF);
      xfer(1'b0, 32'h1000_1004, 32'h0, 32'hDEAD_BEEF, 1'b0, 3, 4'b0010, "rd_s1");

      // back-to-back writes, transfer held high
      @(negedge PCLK);
      transfer = 1'b1; write = 1'b1; addr = 32'h1000_0000; wdata = 32'h1111_1111;
      @(posedge PCLK); #1;
      push_exp(32'hDEAD_BEEF, 1'b0, 2);
      addr = 32'h1000_2008; wdata = 32'h2222_2222;
      @(negedge PCLK);
      check("b2b0_psel", PSEL, 4'b0001);
      wait_ready(10);
      push_exp(32'hDEAD_BEEF, 1'b0, 3);
      check("b2b1_psel", PSEL, 4'b0100);
      check("b2b1_setup", {busy, PENABLE}, 2'b10);
      addr = 32'h1000_300C; wdata = 32'h3333_3333;
      wait_ready(10);
      push_exp(32'hDEAD_BEEF, 1'b0, 3);
      check("b2b2_psel", PSEL, 4'b1000);
      check("b2b2_paddr", PADDR, 32'h1000_300C);
      transfer = 1'b0;
      wait_idle(40);

      xfer(1'b0, 32'h1000_2008, 32'h0, 32'h2222_2222, 1'b0, 3, 4'b0100, "rd_s2");
      xfer(1'b0, 32'h1000_0000, 32'h0, 32'h1111_1111, 1'b0, 2, 4'b0001, "rd_s0");
      xfer(1'b0, 32'h1000_300C, 32'h0, 32'h3333_3333, 1'b0, 3, 4'b1000, "rd_s3");

      // unmapped addresses
      xfer(1'b0, 32'h2000_0000, 32'h0, 32'h0, 1'b1, 2, 4'b0000, "unm_hi");
      xfer(1'b0, 32'h1000_4000, 32'h0, 32'h0, 1'b1, 2, 4'b0000, "unm_mid");
      xfer(1'b0, 32'h1000_1004, 32'h0, 32'hDEAD_BEEF, 1'b0, 3, 4'b0010, "rd_after_err");
      xfer(1'b1, 32'h1000_8000, 32'hAAAA_5555, 32'h0, 1'b1, 2, 4'b0000, "unm_wr");

      // slave 2 hung: 16 ACCESS cycles then error
      hang2 = 1'b1;
      xfer(1'b0, 32'h1000_2008, 32'h0, 32'h0, 1'b1, 17, 4'b0100, "timeout");
      check("timeout_psel_after", PSEL, 4'b0000);
      check("timeout_penable_after", PENABLE, 1'b0);
      hang2 = 1'b0;

      // request during a non-completing ACCESS edge is dropped
      @(negedge PCLK);
      transfer = 1'b1; write = 1'b0; addr = 32'h1000_300C;
      @(posedge PCLK); #1;
      push_exp(32'h3333_3333, 1'b0, 3);
      transfer = 1'b0;
      @(negedge PCLK);
      @(negedge PCLK);
      check("ign_penable", PENABLE, 1'b1);
      transfer = 1'b1; write = 1'b1; addr = 32'h1000_0000;
      @(posedge PCLK); #1;
      transfer = 1'b0;
      @(negedge PCLK);
      check("ign_paddr", PADDR, 32'h1000_300C);
      check("ign_pwrite", PWRITE, 1'b0);
      wait_idle(40);
      repeat (4) @(negedge PCLK);
      check("ign_one_completion", n_done, n_issued);
      check("ign_idle", {busy, state_dbg}, 3'b000);

      // asynchronous reset in the middle of ACCESS
      @(negedge PCLK);
      transfer = 1'b1; write = 1'b0; addr = 32'h1000_1004;
      @(posedge PCLK); #1;
      transfer = 1'b0;
      @(negedge PCLK);
      @(negedge PCLK);
      check("rst_mid_penable_before", PENABLE, 1'b1);
      #2 PRESET = 1'b0;
      #1;
      check("rst_mid_psel", PSEL, 4'b0000);
      check("rst_mid_penable", PENABLE, 1'b0);
      check("rst_mid_busy", busy, 1'b0);
      check("rst_mid_ready", ready, 1'b0);
      check("rst_mid_paddr", PADDR, 32'd0);
      @(negedge PCLK);
      PRESET = 1'b1;
      repeat (4) @(negedge PCLK);
      check("rst_mid_state_after", state_dbg, 2'd0);
      check("rst_mid_ready_after", {ready, busy}, 2'b00);
      check("rst_mid_rdata_after", rdata, 32'd0);

      xfer(1'b0, 32'h1000_1004, 32'h0, 32'hDEAD_BEEF, 1'b0, 3, 4'b0010, "rd_post_rst");
      repeat (3) @(negedge PCLK);
      check("all_completions", n_done, n_issued);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
